// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite types, response/size encodings and the default slave address map.
package ahb_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11} htrans_t;
  localparam logic HRESP_OKAY = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;
  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;
  localparam logic [2:0] HSIZE_DWORD = 3'b011;
  localparam logic [3:0][31:0] DEFAULT_BASE = {32'h2000_0000, 32'h1000_0000, 32'h0001_0000, 32'h0000_0000};
  localparam logic [3:0][31:0] DEFAULT_MASK = {32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_0000, 32'hFFFF_0000};
endpackage

// File: rtl/ahb_default_slave.sv
// ahb_default_slave: answers unmapped NONSEQ/SEQ transfers with the two-cycle ERROR response.
module ahb_default_slave
  import ahb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       sel,
  input  logic [1:0] htrans,
  input  logic       hready,
  output logic       hreadyout,
  output logic       hresp
);
  typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} state_t;
  state_t state, state_nxt;
  logic start;
  assign start = sel && hready && (htrans == NONSEQ || htrans == SEQ);
  always_ff @(posedge clk)
    state <= !reset ? DS_IDLE : state_nxt;
  always_comb begin
    state_nxt = state;
    hreadyout = state != DS_ERR1;
    hresp = state == DS_IDLE ? HRESP_OKAY : HRESP_ERROR;
    state_nxt = state == DS_ERR1 ? DS_ERR2 : start ? DS_ERR1 : DS_IDLE;
  end
endmodule

// File: rtl/ahb_lite_multislave_ic.sv
// ahb_lite_multislave_ic: single-master AHB-Lite interconnect with base/mask decode,
// registered data-phase select, response mux and a built-in default (error) slave.
module ahb_lite_multislave_ic
  import ahb_pkg::*;
#(
  parameter int N_SLAVES = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [N_SLAVES-1:0][ADDR_W-1:0] SLAVE_BASE = DEFAULT_BASE,
  parameter logic [N_SLAVES-1:0][ADDR_W-1:0] SLAVE_MASK = DEFAULT_MASK
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [ADDR_W-1:0]                haddr,
  input  logic [1:0]                       htrans,
  input  logic                             hwrite,
  input  logic [2:0]                       hsize,
  input  logic [3:0]                       hprot,
  input  logic [DATA_W-1:0]                hwdata,
  output logic [DATA_W-1:0]                hrdata,
  output logic                             hready,
  output logic                             hresp,
  output logic [N_SLAVES-1:0]              hsel_s,
  output logic [ADDR_W-1:0]                haddr_s,
  output logic [1:0]                       htrans_s,
  output logic                             hwrite_s,
  output logic [2:0]                       hsize_s,
  output logic [3:0]                       hprot_s,
  output logic [DATA_W-1:0]                hwdata_s,
  input  logic [N_SLAVES-1:0][DATA_W-1:0]  hrdata_s,
  input  logic [N_SLAVES-1:0]              hreadyout_s,
  input  logic [N_SLAVES-1:0]              hresp_s
);
  logic [N_SLAVES-1:0] hit;
  logic [N_SLAVES:0] dsel;
  logic dflt_sel, dflt_hreadyout, dflt_hresp;
  assign haddr_s = haddr;
  assign htrans_s = htrans;
  assign hwrite_s = hwrite;
  assign hsize_s = hsize;
  assign hprot_s = hprot;
  assign hwdata_s = hwdata;
  genvar i;
  for (i = 0; i < N_SLAVES; i++) begin : g_dec
    assign hit[i] = (haddr & SLAVE_MASK[i]) == SLAVE_BASE[i];
  end
  // Lowest index wins on overlapping regions, keeping hsel_s one-hot.
  always_comb begin
    hsel_s = '0;
    dflt_sel = 1'b1;
    for (int k = 0; k < N_SLAVES; k++)
      if (hit[k] && dflt_sel) begin
        hsel_s[k] = 1'b1;
        dflt_sel = 1'b0;
      end
  end
  always_ff @(posedge clk)
    if (!reset) dsel <= {1'b1, {N_SLAVES{1'b0}}};
    else if (hready) dsel <= {dflt_sel, hsel_s};
  always_comb begin
    hrdata = '0;
    hready = dsel[N_SLAVES] ? dflt_hreadyout : 1'b0;
    hresp = dsel[N_SLAVES] && dflt_hresp;
    for (int k = 0; k < N_SLAVES; k++)
      if (dsel[k]) begin
        hrdata = hrdata_s[k];
        hready = hreadyout_s[k];
        hresp = hresp_s[k];
      end
  end
  ahb_default_slave u_dflt (
    .clk       (clk),
    .reset     (reset),
    .sel       (dflt_sel),
    .htrans    (htrans),
    .hready    (hready),
    .hreadyout (dflt_hreadyout),
    .hresp     (dflt_hresp)
  );
endmodule

// File: tb/tb_ahb_lite_multislave_ic.sv
// tb_ahb_lite_multislave_ic: directed bench for decode, wait-state stretching,
// default-slave ERROR sequencing and mid-transfer reset.
module tb_ahb_lite_multislave_ic;
  logic clk = 1'b0;
  logic reset;
  logic [31:0] haddr;
  logic [1:0] htrans;
  logic hwrite;
  logic [2:0] hsize;
  logic [3:0] hprot;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic hready, hresp;
  logic [3:0] hsel_s;
  logic [31:0] haddr_s;
  logic [1:0] htrans_s;
  logic hwrite_s;
  logic [2:0] hsize_s;
  logic [3:0] hprot_s;
  logic [31:0] hwdata_s;
  logic [3:0][31:0] hrdata_s;
  logic [3:0] hreadyout_s;
  logic [3:0] hresp_s;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ahb_lite_multislave_ic dut (
    .clk(clk), .reset(reset), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .hprot(hprot), .hwdata(hwdata), .hrdata(hrdata), .hready(hready),
    .hresp(hresp), .hsel_s(hsel_s), .haddr_s(haddr_s), .htrans_s(htrans_s),
    .hwrite_s(hwrite_s), .hsize_s(hsize_s), .hprot_s(hprot_s), .hwdata_s(hwdata_s),
    .hrdata_s(hrdata_s), .hreadyout_s(hreadyout_s), .hresp_s(hresp_s)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic rsp(input string tag, input logic rdy, input logic err, input logic [31:0] data);
    #1;
    chk({tag, "_hready"}, 64'(hready), 64'(rdy));
    chk({tag, "_hresp"}, 64'(hresp), 64'(err));
    chk({tag, "_hrdata"}, 64'(hrdata), 64'(data));
  endtask

  initial begin
    reset = 1'b0;
    haddr = 32'h0;
    htrans = 2'b00;
    hwrite = 1'b0;
    hsize = 3'b010;
    hprot = 4'h3;
    hwdata = 32'h5555_AAAA;
    hrdata_s = {32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF, 32'hA0A0_0000};
    hreadyout_s = 4'hF;
    hresp_s = 4'h0;
    step;
    step;
    rsp("reset", 1'b1, 1'b0, 32'h0);
    chk("bcast_haddr", 64'(haddr_s), 64'h0);
    chk("bcast_hwdata", 64'(hwdata_s), 64'h5555_AAAA);
    reset = 1'b1;
    haddr = 32'h0001_0004;
    htrans = 2'b10;
    #1;
    chk("dec_s1", 64'(hsel_s), 64'h2);
    step;
    haddr = 32'h0000_0010;
    rsp("rd_s1", 1'b1, 1'b0, 32'hDEAD_BEEF);
    chk("dec_s0", 64'(hsel_s), 64'h1);
    step;
    hreadyout_s[0] = 1'b0;
    haddr = 32'h1000_0000;
    #1;
    chk("dec_s2", 64'(hsel_s), 64'h4);
    rsp("wait1", 1'b0, 1'b0, 32'hA0A0_0000);
    step;
    rsp("wait2", 1'b0, 1'b0, 32'hA0A0_0000);
    step;
    rsp("wait3", 1'b0, 1'b0, 32'hA0A0_0000);
    step;
    hreadyout_s[0] = 1'b1;
    rsp("wait_done", 1'b1, 1'b0, 32'hA0A0_0000);
    step;
    haddr = 32'h3000_0000;
    rsp("rd_s2", 1'b1, 1'b0, 32'h2222_2222);
    chk("dec_none", 64'(hsel_s), 64'h0);
    step;
    htrans = 2'b00;
    rsp("err1", 1'b0, 1'b1, 32'h0);
    step;
    rsp("err2", 1'b1, 1'b1, 32'h0);
    step;
    rsp("idle_unmapped", 1'b1, 1'b0, 32'h0);
    htrans = 2'b10;
    step;
    haddr = 32'h3000_0004;
    rsp("b2b_err1a", 1'b0, 1'b1, 32'h0);
    step;
    rsp("b2b_err2a", 1'b1, 1'b1, 32'h0);
    step;
    htrans = 2'b00;
    rsp("b2b_err1b", 1'b0, 1'b1, 32'h0);
    step;
    rsp("b2b_err2b", 1'b1, 1'b1, 32'h0);
    step;
    rsp("b2b_idle", 1'b1, 1'b0, 32'h0);
    htrans = 2'b10;
    step;
    rsp("rst_err1", 1'b0, 1'b1, 32'h0);
    reset = 1'b0;
    htrans = 2'b00;
    step;
    rsp("rst_mid", 1'b1, 1'b0, 32'h0);
    reset = 1'b1;
    haddr = 32'h2000_0008;
    htrans = 2'b10;
    hresp_s[3] = 1'b1;
    #1;
    chk("dec_s3", 64'(hsel_s), 64'h8);
    step;
    htrans = 2'b00;
    rsp("resume_s3", 1'b1, 1'b1, 32'h3333_3333);
    step;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ahb_lite_multislave_ic.md
# ahb_lite_multislave_ic

Parametrised AHB-Lite single-master interconnect between the core master port and N slaves (instruction memory, data memory, peripherals). Decodes the address phase into one-hot slave selects via a base/mask map, registers the selection into the data phase, and multiplexes read data and responses back to the core. Any transfer to an unmapped address is answered by a built-in default slave with the two-cycle AHB ERROR response. This generalises the current two-slave combinational inst/data interconnect.

## Interface
- N_SLAVES, 4, number of slave ports (1..16)
- ADDR_W, 32, address width
- DATA_W, 32, data width (32 or 64)
- SLAVE_BASE, {0x2000_0000, 0x1000_0000, 0x0001_0000, 0x0000_0000}, [N_SLAVES-1:0][ADDR_W-1:0] region bases; index 0 is rightmost
- SLAVE_MASK, {0xFFFF_F000, 0xFFFF_F000, 0xFFFF_0000, 0xFFFF_0000}, per-region compare masks
- clk  in  1  single clock
- reset  in  1  synchronous, active-low reset
- haddr  in  ADDR_W  master address
- htrans  in  2  master transfer type
- hwrite, hsize[2:0], hprot[3:0], hwdata[DATA_W]  in  master control and write data
- hrdata  out  DATA_W  muxed read data to master
- hready  out  1  global HREADY; also driven to every slave as HREADYIN
- hresp  out  1  muxed response (0 OKAY, 1 ERROR)
- hsel_s  out  N_SLAVES  one-hot address-phase slave select
- haddr_s, htrans_s, hwrite_s, hsize_s, hprot_s, hwdata_s  out  broadcast copies of master signals
- hrdata_s  in  [N_SLAVES][DATA_W]  slave read data
- hreadyout_s  in  N_SLAVES  slave HREADYOUT
- hresp_s  in  N_SLAVES  slave HRESP

## Operation
- Decode (combinational): slave i hits when (haddr & SLAVE_MASK[i]) == SLAVE_BASE[i]. On overlapping regions the lowest index wins; hsel_s stays one-hot. No hit selects the default slave, and all hsel_s bits are 0.
- Data-phase register `dsel`: a one-hot over N_SLAVES+1, where bit N is the default slave. It loads the decode result on a rising clk only when hready=1. It holds while hready=0.
- Response mux: while `dsel` selects slave i, hrdata=hrdata_s[i], hready=hreadyout_s[i], hresp=hresp_s[i].
- Default slave FSM (sub-module) has states IDLE, ERR1, ERR2:
  - IDLE -> ERR1 when default is decoded, hready=1 and htrans is NONSEQ or SEQ.
  - ERR1: drives hready=0, hresp=1. Moves to ERR2 on the next cycle.
  - ERR2: drives hready=1, hresp=1. Moves to ERR1 if a new unmapped NONSEQ/SEQ is accepted, otherwise to IDLE.
  - IDLE: drives hready=1, hresp=0.
  - IDLE/BUSY to an unmapped address gets a zero-wait OKAY.
- hrdata is 0 whenever the default slave owns the data phase.
- Reset (reset=0 at a rising clk, including mid-transfer): `dsel` = default, FSM = IDLE. Outputs become hready=1, hresp=0, hrdata=0, and any in-flight transfer is abandoned.
- Broadcast outputs are pure wires and carry no reset value.

## Timing
- Address-to-data latency is one cycle. hsel_s is combinational from haddr in the same cycle.
- hready, hresp and hrdata are combinational from `dsel` and the slave inputs; there is no added wait state.
- A slave inserting k wait states stretches the data phase by k cycles. The next address phase is held and `dsel` does not change.
- An unmapped NONSEQ costs exactly one wait cycle (ERR1) before completing with ERROR in ERR2.
- Back-to-back transfers to different slaves switch the mux on the cycle after the previous data phase completes.

## Structure
- Shared package `ahb_pkg` holds:
  - htrans_t enum (IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11)
  - HRESP_OKAY/HRESP_ERROR constants
  - hsize encodings
  - default map constants
- Sub-module `ahb_default_slave`: the 3-state FSM. Inputs are clk, reset, sel, htrans and hready; outputs are hreadyout and hresp.
- The decoder and mux are a generate loop inside the top.

## Test plan
- NONSEQ read at 0x0001_0004 with slave1 returning 0xDEAD_BEEF at zero wait -> hsel_s=4'b0010 in the address cycle; next cycle hrdata=0xDEAD_BEEF, hready=1, hresp=0.
- Slave0 holds hreadyout_s[0]=0 for 3 cycles while the next address (0x1000_0000) is presented -> hready=0 for 3 cycles, `dsel` stays slave0, then switches to slave2.
- NONSEQ at unmapped 0x3000_0000 -> cycle 1: hready=0, hresp=1; cycle 2: hready=1, hresp=1; all hsel_s=0, hrdata=0.
- IDLE at unmapped 0x3000_0000 -> hready=1, hresp=0 with no wait.
- Two consecutive unmapped NONSEQs -> ERR1, ERR2, ERR1, ERR2, with no OKAY in between.
- Assert reset=0 during ERR1 -> next cycle hready=1, hresp=0, hrdata=0, FSM IDLE; transfers resume normally after release.
